// File: rtl/c4_pkg.sv
// Shared constants, encodings and board indexing helpers for the Connect-Four controller.
package c4_pkg;
  localparam int unsigned NUM_COLS = 7;
  localparam int unsigned NUM_ROWS = 6;
  localparam int unsigned BOARD_W  = 2 * NUM_COLS * NUM_ROWS;

  typedef logic [BOARD_W-1:0] board_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_RED   = 2'b01;
  localparam logic [1:0] CELL_YEL   = 2'b10;

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_FALL  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [1:0] DIR_H  = 2'd0;
  localparam logic [1:0] DIR_V  = 2'd1;
  localparam logic [1:0] DIR_UR = 2'd2;
  localparam logic [1:0] DIR_DR = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_RED  = 2'b01;
  localparam logic [1:0] WIN_YEL  = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Bit offset of cell (col,row); column c occupies bits [12c+11:12c].
  function automatic logic [6:0] cell_idx(input int col, input int row);
    return 7'(12 * col + 2 * row);
  endfunction

  function automatic logic in_board(input int col, input int row);
    return (col >= 0) && (col < int'(NUM_COLS)) && (row >= 0) && (row < int'(NUM_ROWS));
  endfunction
endpackage

// File: rtl/c4_line_count.sv
// Run length of same-colour cells through (col,row) along one direction, including the cell itself.
module c4_line_count
  import c4_pkg::*;
(
  input  board_t     board,
  input  logic [2:0] col,
  input  logic [2:0] row,
  input  logic [1:0] dir,
  input  logic [1:0] colour,
  output logic [2:0] len
);
  int dc, dr, pc, pr, nc, nr;
  logic [2:0] pos, neg;
  logic pos_run, neg_run;

  always_comb begin
    dc = 1;
    dr = 0;
    unique case (dir)
      DIR_H:  begin dc = 1; dr = 0;  end
      DIR_V:  begin dc = 0; dr = 1;  end
      DIR_UR: begin dc = 1; dr = 1;  end
      DIR_DR: begin dc = 1; dr = -1; end
    endcase
    pos = 3'd0;
    neg = 3'd0;
    pos_run = 1'b1;
    neg_run = 1'b1;
    pc = 0; pr = 0; nc = 0; nr = 0;
    for (int k = 1; k <= 3; k++) begin
      pc = int'(col) + k * dc;
      pr = int'(row) + k * dr;
      nc = int'(col) - k * dc;
      nr = int'(row) - k * dr;
      if (pos_run && in_board(pc, pr) && (board[cell_idx(pc, pr) +: 2] == colour)) pos = pos + 3'd1;
      else pos_run = 1'b0;
      if (neg_run && in_board(nc, nr) && (board[cell_idx(nc, nr) +: 2] == colour)) neg = neg + 3'd1;
      else neg_run = 1'b0;
    end
    len = 3'd1 + pos + neg;
  end
endmodule

// File: rtl/c4_game_ctrl.sv
// Connect-Four sequencer: cursor, piece drop animation, win/draw detection and board ownership.
module c4_game_ctrl
  import c4_pkg::*;
#(
  parameter int unsigned DROP_TICKS = 4,
  parameter int unsigned START_COL  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_drop,
  input  logic        btn_new,
  input  logic        tick,
  output logic [2:0]  A,
  output logic        player_colour,
  output logic [11:0] col1,
  output logic [11:0] col2,
  output logic [11:0] col3,
  output logic [11:0] col4,
  output logic [11:0] col5,
  output logic [11:0] col6,
  output logic [11:0] col7,
  output logic        busy,
  output logic        game_over,
  output logic [1:0]  winner
);
  logic [1:0] state, state_n, dir, dir_n, winner_n;
  logic [2:0] a_n, row, row_n, len;
  logic [5:0] moves, moves_n;
  logic [3:0] tcnt, tcnt_n;
  logic       player_n, win, win_n, win_acc, busy_n, game_over_n;
  board_t     board, board_n;
  logic       left_q, right_q, drop_q, new_q;
  logic       left_e, right_e, drop_e, new_e;
  logic [1:0] colour;
  logic [6:0] cur_idx, below_idx, top_idx;

  assign left_e  = btn_left  & ~left_q;
  assign right_e = btn_right & ~right_q;
  assign drop_e  = btn_drop  & ~drop_q;
  assign new_e   = btn_new   & ~new_q;
  assign colour  = player_colour ? CELL_YEL : CELL_RED;
  assign cur_idx   = cell_idx(int'(A), int'(row));
  assign below_idx = cell_idx(int'(A), int'(row) - 1);
  assign top_idx   = cell_idx(int'(A), 5);

  assign {col7, col6, col5, col4, col3, col2, col1} = board;

  c4_line_count u_line (
    .board (board),
    .col   (A),
    .row   (row),
    .dir   (dir),
    .colour(colour),
    .len   (len)
  );

  assign win_acc = win | (len >= 3'd4);

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    a_n         = A;
    player_n    = player_colour;
    board_n     = board;
    row_n       = row;
    moves_n     = moves;
    tcnt_n      = tcnt;
    dir_n       = dir;
    win_n       = win;
    winner_n    = winner;
    busy_n      = busy;
    game_over_n = game_over;
    if (new_e) begin
      state_n     = ST_PLAY;
      a_n         = 3'(START_COL);
      player_n    = 1'b0;
      board_n     = '0;
      row_n       = 3'd0;
      moves_n     = 6'd0;
      tcnt_n      = 4'd0;
      dir_n       = DIR_H;
      win_n       = 1'b0;
      winner_n    = WIN_NONE;
      busy_n      = 1'b0;
      game_over_n = 1'b0;
    end else begin
      unique case (state)
        ST_PLAY: begin
          if (drop_e) begin
            if (board[top_idx +: 2] == CELL_EMPTY) begin
              board_n[top_idx +: 2] = colour;
              row_n   = 3'd5;
              tcnt_n  = 4'd0;
              busy_n  = 1'b1;
              state_n = ST_FALL;
            end
          end else if (right_e && !left_e) begin
            a_n = (A == 3'd6) ? 3'd0 : A + 3'd1;
          end else if (left_e && !right_e) begin
            a_n = (A == 3'd0) ? 3'd6 : A - 3'd1;
          end
        end
        ST_FALL: begin
          if (tick) begin
            if (tcnt == 4'(DROP_TICKS - 1)) begin
              tcnt_n = 4'd0;
              if ((row != 3'd0) && (board[below_idx +: 2] == CELL_EMPTY)) begin
                board_n[cur_idx +: 2]   = CELL_EMPTY;
                board_n[below_idx +: 2] = colour;
                row_n = row - 3'd1;
              end else begin
                dir_n   = DIR_H;
                win_n   = 1'b0;
                state_n = ST_CHECK;
              end
            end else begin
              tcnt_n = tcnt + 4'd1;
            end
          end
        end
        ST_CHECK: begin
          dir_n = dir + 2'd1;
          win_n = win_acc;
          if (dir == DIR_DR) begin
            if (win_acc) begin
              winner_n    = player_colour ? WIN_YEL : WIN_RED;
              state_n     = ST_OVER;
              busy_n      = 1'b0;
              game_over_n = 1'b1;
            end else begin
              moves_n = moves + 6'd1;
              busy_n  = 1'b0;
              if (moves_n == 6'd42) begin
                winner_n    = WIN_DRAW;
                state_n     = ST_OVER;
                game_over_n = 1'b1;
              end else begin
                player_n = ~player_colour;
                state_n  = ST_PLAY;
              end
            end
          end
        end
        ST_OVER: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_PLAY;
      A             <= 3'(START_COL);
      player_colour <= 1'b0;
      board         <= '0;
      row           <= 3'd0;
      moves         <= 6'd0;
      tcnt          <= 4'd0;
      dir           <= DIR_H;
      win           <= 1'b0;
      winner        <= WIN_NONE;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      drop_q        <= 1'b0;
      new_q         <= 1'b0;
    end else begin
      state         <= state_n;
      A             <= a_n;
      player_colour <= player_n;
      board         <= board_n;
      row           <= row_n;
      moves         <= moves_n;
      tcnt          <= tcnt_n;
      dir           <= dir_n;
      win           <= win_n;
      winner        <= winner_n;
      busy          <= busy_n;
      game_over     <= game_over_n;
      left_q        <= btn_left;
      right_q       <= btn_right;
      drop_q        <= btn_drop;
      new_q         <= btn_new;
    end
  end
endmodule

// File: tb/tb_c4_game_ctrl.sv
// Bench for c4_game_ctrl: game-level reference model checked every cycle plus directed literal checks.
module tb_c4_game_ctrl;
  localparam int DT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0, btn_new = 1'b0, tick = 1'b0;
  logic [2:0]  A;
  logic        player_colour, busy, game_over;
  logic [11:0] col1, col2, col3, col4, col5, col6, col7;
  logic [1:0]  winner;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  c4_game_ctrl #(.DROP_TICKS(DT), .START_COL(3)) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .btn_drop(btn_drop), .btn_new(btn_new), .tick(tick), .A(A),
    .player_colour(player_colour), .col1(col1), .col2(col2), .col3(col3),
    .col4(col4), .col5(col5), .col6(col6), .col7(col7), .busy(busy),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Game model: board as a grid, column heights, phase 0 play / 1 fall / 2 check / 3 over
  int mb[7][6];
  int mh[7];
  int ma, mp, ms, frow, ftick, ccnt, mmoves, mwinner;
  bit mwin, ql, qr, qd, qn;

  function automatic bit any_four();
    int dc, dr, c, r;
    bit hit;
    hit = 1'b0;
    for (int d = 0; d < 4; d++) begin
      dc = (d == 1) ? 0 : 1;
      dr = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
      for (int c0 = 0; c0 < 7; c0++)
        for (int r0 = 0; r0 < 6; r0++) begin
          c = c0 + 3 * dc;
          r = r0 + 3 * dr;
          if (c >= 0 && c < 7 && r >= 0 && r < 6 && mb[c0][r0] != 0 &&
              mb[c0][r0] == mb[c0+dc][r0+dr] && mb[c0][r0] == mb[c0+2*dc][r0+2*dr] &&
              mb[c0][r0] == mb[c][r])
            hit = 1'b1;
        end
    end
    return hit;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 7; c++) begin
      mh[c] = 0;
      for (int r = 0; r < 6; r++) mb[c][r] = 0;
    end
    ma = 3; mp = 0; ms = 0; frow = 0; ftick = 0; ccnt = 0; mmoves = 0; mwinner = 0; mwin = 1'b0;
  endtask

  task automatic model_step();
    bit le, re, de, ne;
    le = btn_left && !ql;
    re = btn_right && !qr;
    de = btn_drop && !qd;
    ne = btn_new && !qn;
    ql = btn_left; qr = btn_right; qd = btn_drop; qn = btn_new;
    if (ne) begin
      model_clear();
      return;
    end
    case (ms)
      0: begin
        if (de) begin
          if (mh[ma] < 6) begin
            mb[ma][5] = mp + 1; frow = 5; ftick = 0; ms = 1;
          end
        end else if (re && !le) ma = (ma + 1) % 7;
        else if (le && !re) ma = (ma + 6) % 7;
      end
      1: if (tick) begin
        ftick++;
        if (ftick == DT) begin
          ftick = 0;
          if (frow > mh[ma]) begin
            mb[ma][frow] = 0; frow--; mb[ma][frow] = mp + 1;
          end else begin
            mh[ma]++; ms = 2; ccnt = 0; mwin = any_four();
          end
        end
      end
      2: begin
        ccnt++;
        if (ccnt == 4) begin
          if (mwin) begin mwinner = mp + 1; ms = 3; end
          else begin
            mmoves++;
            if (mmoves == 42) begin mwinner = 3; ms = 3; end
            else begin mp ^= 1; ms = 0; end
          end
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear();
      ql = 1'b0; qr = 1'b0; qd = 1'b0; qn = 1'b0;
    end else model_step();
  end

  function automatic logic [83:0] model_board();
    logic [83:0] b;
    b = '0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) b[12*c+2*r +: 2] = 2'(mb[c][r]);
    return b;
  endfunction

  task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("A", 84'(A), 84'(ma));
      chk("player_colour", 84'(player_colour), 84'(mp));
      chk("board", {col7, col6, col5, col4, col3, col2, col1}, model_board());
      chk("busy", 84'(busy), 84'(ms == 1 || ms == 2));
      chk("game_over", 84'(game_over), 84'(ms == 3));
      chk("winner", 84'(winner), 84'(mwinner));
    end
  end

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: btn_left = 1'b1;
      1: btn_right = 1'b1;
      2: btn_drop = 1'b1;
      default: btn_new = 1'b1;
    endcase
    @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0; btn_new = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic run_fall();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      ticks(1);
      n++;
    end
    chk("fall_done", 84'(busy), 84'(0));
  endtask

  task automatic move_to(input int c);
    for (int i = 0; i < 7 && ma != c; i++) pulse(1);
  endtask

  task automatic drop_at(input int c);
    move_to(c);
    pulse(2);
    run_fall();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_A", 84'(A), 84'(3));
    chk("rst_player", 84'(player_colour), 84'(0));
    chk("rst_board", {col7, col6, col5, col4, col3, col2, col1}, 84'(0));
    chk("rst_winner", 84'(winner), 84'(0));
    chk("rst_busy", 84'(busy), 84'(0));

    // Cursor wrap, held button, simultaneous left+right
    repeat (3) pulse(1);
    chk("A_at_6", 84'(A), 84'(6));
    pulse(1);
    chk("A_wrap_right", 84'(A), 84'(0));
    @(negedge clk) btn_left = 1'b1;
    repeat (10) @(negedge clk);
    btn_left = 1'b0;
    chk("A_held_left", 84'(A), 84'(6));
    @(negedge clk) begin btn_left = 1'b1; btn_right = 1'b1; end
    @(negedge clk) begin btn_left = 1'b0; btn_right = 1'b0; end
    chk("A_left_right", 84'(A), 84'(6));

    // Single drop animation timing in empty column 3
    repeat (3) pulse(0);
    pulse(2);
    chk("col4_top", 84'(col4), 84'(12'h400));
    ticks(20);
    chk("col4_bottom", 84'(col4), 84'(12'h001));
    chk("busy_falling", 84'(busy), 84'(1));
    ticks(4);
    repeat (4) @(negedge clk);
    chk("busy_after_check", 84'(busy), 84'(0));
    chk("player_yellow", 84'(player_colour), 84'(1));
    ticks(6);
    chk("col4_idle", 84'(col4), 84'(12'h001));

    // Red horizontal win along the bottom row
    pulse(3);
    drop_at(0); drop_at(6); drop_at(1); drop_at(6); drop_at(2); drop_at(6); drop_at(3);
    chk("win_winner", 84'(winner), 84'(1));
    chk("win_over", 84'(game_over), 84'(1));
    pulse(2);
    ticks(30);
    chk("over_col4", 84'(col4), 84'(12'h001));
    chk("over_col7", 84'(col7), 84'(12'h02A));

    // Full column rejects a drop
    pulse(3);
    for (int i = 0; i < 6; i++) drop_at(0);
    chk("full_col1", 84'(col1), 84'(12'h999));
    pulse(2);
    chk("full_busy", 84'(busy), 84'(0));
    chk("full_player", 84'(player_colour), 84'(0));

    // New game while a piece is falling
    move_to(2);
    pulse(2);
    ticks(5);
    pulse(3);
    chk("new_board", {col7, col6, col5, col4, col3, col2, col1}, 84'(0));
    chk("new_A", 84'(A), 84'(3));
    chk("new_busy", 84'(busy), 84'(0));

    // 42-move draw: paired columns keep every line at most two long
    for (int p = 0; p < 3; p++) begin
      int ca, cb;
      ca = (p == 0) ? 0 : ((p == 1) ? 1 : 4);
      cb = (p == 0) ? 2 : ((p == 1) ? 3 : 6);
      for (int k = 0; k < 3; k++) begin
        drop_at(ca); drop_at(cb); drop_at(cb); drop_at(ca);
      end
    end
    for (int k = 0; k < 6; k++) drop_at(5);
    chk("draw_winner", 84'(winner), 84'(3));
    chk("draw_over", 84'(game_over), 84'(1));

    // Asynchronous reset while in CHECK
    pulse(3);
    move_to(0);
    pulse(2);
    ticks(24);
    chk("in_check_busy", 84'(busy), 84'(1));
    #2 reset = 1'b1;
    #1;
    chk("arst_A", 84'(A), 84'(3));
    chk("arst_board", {col7, col6, col5, col4, col3, col2, col1}, 84'(0));
    chk("arst_busy", 84'(busy), 84'(0));
    chk("arst_player", 84'(player_colour), 84'(0));
    chk("arst_over", 84'(game_over), 84'(0));
    chk("arst_winner", 84'(winner), 84'(0));
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
